// File: rtl/md_issue.sv
`default_nettype none
// ============================================================================
//  Module      : md_issue
//  Description : Issue control between the E stage and a multi-cycle
//                multiply/divide unit. Accepts MD-class instructions from E,
//                presents each start operation to the unit for exactly one
//                cycle, waits out the unit's busy time, stalls dependent MD
//                instructions, returns MFHI/MFLO results to M, and supports
//                cancelling an operation in its issue cycle.
//  Ports       : clk, rst (async, active-low)
//                e_valid, e_cls[3:0], e_rs/e_rt[31:0], flush   - E stage
//                md_busy, md_invalid, md_hi/md_lo[31:0]        - from MD unit
//                md_op[3:0], md_dh/md_dl[31:0], md_stop        - to MD unit
//                stall                                         - pipeline freeze
//                mf_valid, mf_data[31:0]                       - to M stage
//                div0, issue_cnt[CNT_W-1:0]                    - status
//  Revision    : 1.0  initial release
// ============================================================================
module md_issue #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             e_valid,
    input  logic [3:0]       e_cls,
    input  logic [31:0]      e_rs,
    input  logic [31:0]      e_rt,
    input  logic             flush,
    input  logic             md_busy,
    input  logic             md_invalid,
    input  logic [31:0]      md_hi,
    input  logic [31:0]      md_lo,
    output logic [3:0]       md_op,
    output logic [31:0]      md_dh,
    output logic [31:0]      md_dl,
    output logic             md_stop,
    output logic             stall,
    output logic             mf_valid,
    output logic [31:0]      mf_data,
    output logic             div0,
    output logic [CNT_W-1:0] issue_cnt
);

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MFHI  = 4'd7;
    localparam logic [3:0] MD_MFLO  = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         md_op_q;
    logic [31:0]        md_dh_q, md_dl_q;
    logic               mf_valid_q;
    logic [31:0]        mf_data_q;
    logic               div0_q;
    logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;

    logic is_start, is_read, accept, rd_accept, stop;

    // The unit's invalid flag is status only; control never looks at it.
    logic unused_md_invalid;
    assign unused_md_invalid = md_invalid;

    always_comb begin
        is_start  = e_valid && (e_cls >= MD_MULT) && (e_cls <= MD_MTLO);
        is_read   = e_valid && ((e_cls == MD_MFHI) || (e_cls == MD_MFLO));
        stall     = (is_start || is_read) && ((state_q != S_IDLE) || md_busy);
        // With stall low an MD instruction implies IDLE and a quiet unit.
        accept    = is_start && !stall && !flush;
        rd_accept = is_read && !stall && !flush;
        // Only an operation still in its issue cycle can be withdrawn.
        stop      = (state_q == S_ISSUE) && flush;
    end

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if ((md_op_q >= MD_MULT) && (md_op_q <= MD_DIVU)) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!md_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Accept (IDLE) and stop (ISSUE) are mutually exclusive; a stopped
        // operation takes its count back so the net effect is zero.
        if (accept) begin
            issue_cnt_d = issue_cnt_q + CNT_W'(1);
        end else if (stop) begin
            issue_cnt_d = issue_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            md_op_q     <= MD_NONE;
            md_dh_q     <= '0;
            md_dl_q     <= '0;
            mf_valid_q  <= 1'b0;
            mf_data_q   <= '0;
            div0_q      <= 1'b0;
            issue_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            md_op_q     <= accept ? e_cls : MD_NONE;
            if (accept) begin
                md_dh_q <= e_rs;
                md_dl_q <= e_rt;
            end
            div0_q     <= accept && ((e_cls == MD_DIV) || (e_cls == MD_DIVU)) &&
                          (e_rt == 32'd0);
            mf_valid_q <= rd_accept;
            if (rd_accept) begin
                mf_data_q <= (e_cls == MD_MFHI) ? md_hi : md_lo;
            end
        end
    end

    assign md_op     = md_op_q;
    assign md_dh     = md_dh_q;
    assign md_dl     = md_dl_q;
    assign md_stop   = stop;
    assign mf_valid  = mf_valid_q;
    assign mf_data   = mf_data_q;
    assign div0      = div0_q;
    assign issue_cnt = issue_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_md_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_issue
//  Description : Self-checking bench for md_issue with a behavioural
//                multiply/divide unit (busy for 5 cycles per mult/div).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_md_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        e_valid = 1'b0;
    logic [3:0]  e_cls = 4'd0;
    logic [31:0] e_rs = 32'd0, e_rt = 32'd0;
    logic        flush = 1'b0;
    logic        md_busy;
    logic        md_invalid = 1'b0;
    logic [31:0] md_hi, md_lo;
    logic [3:0]  md_op;
    logic [31:0] md_dh, md_dl;
    logic        md_stop, stall, mf_valid, div0;
    logic [31:0] mf_data;
    logic [15:0] issue_cnt;

    // Narrow-counter instance sharing all inputs, used for the wrap check.
    logic [3:0]  o4_md_op;
    logic [31:0] o4_md_dh, o4_md_dl, o4_mf_data;
    logic        o4_md_stop, o4_stall, o4_mf_valid, o4_div0;
    logic [3:0]  cnt4;

    always #5 clk = ~clk;

    md_issue dut (
        .clk(clk), .rst(rst), .e_valid(e_valid), .e_cls(e_cls), .e_rs(e_rs),
        .e_rt(e_rt), .flush(flush), .md_busy(md_busy), .md_invalid(md_invalid),
        .md_hi(md_hi), .md_lo(md_lo), .md_op(md_op), .md_dh(md_dh),
        .md_dl(md_dl), .md_stop(md_stop), .stall(stall), .mf_valid(mf_valid),
        .mf_data(mf_data), .div0(div0), .issue_cnt(issue_cnt)
    );

    md_issue #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .e_valid(e_valid), .e_cls(e_cls), .e_rs(e_rs),
        .e_rt(e_rt), .flush(flush), .md_busy(md_busy), .md_invalid(md_invalid),
        .md_hi(md_hi), .md_lo(md_lo), .md_op(o4_md_op), .md_dh(o4_md_dh),
        .md_dl(o4_md_dl), .md_stop(o4_md_stop), .stall(o4_stall),
        .mf_valid(o4_mf_valid), .mf_data(o4_mf_data), .div0(o4_div0),
        .issue_cnt(cnt4)
    );

    // ---------------- behavioural multiply/divide unit ----------------------
    logic [2:0]  u_cnt;
    logic [63:0] u_res;
    assign md_busy = (u_cnt != 3'd0);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            u_cnt <= 3'd0; u_res <= 64'd0; md_hi <= 32'd0; md_lo <= 32'd0;
        end else begin
            if (u_cnt != 3'd0) begin
                u_cnt <= u_cnt - 3'd1;
                if (u_cnt == 3'd1) begin
                    md_hi <= u_res[63:32];
                    md_lo <= u_res[31:0];
                end
            end
            if (!md_stop) begin
                case (md_op)
                    4'd1: begin
                        u_res <= $signed({{32{md_dh[31]}}, md_dh}) *
                                 $signed({{32{md_dl[31]}}, md_dl});
                        u_cnt <= 3'd5;
                    end
                    4'd2: begin
                        u_res <= {32'd0, md_dh} * {32'd0, md_dl};
                        u_cnt <= 3'd5;
                    end
                    4'd3: begin
                        if (md_dl != 32'd0)
                            u_res <= {32'($signed(md_dh) % $signed(md_dl)),
                                      32'($signed(md_dh) / $signed(md_dl))};
                        else
                            u_res <= {md_hi, md_lo};
                        u_cnt <= 3'd5;
                    end
                    4'd4: begin
                        if (md_dl != 32'd0)
                            u_res <= {md_dh % md_dl, md_dh / md_dl};
                        else
                            u_res <= {md_hi, md_lo};
                        u_cnt <= 3'd5;
                    end
                    4'd5: md_hi <= md_dh;
                    4'd6: md_lo <= md_dh;
                    default: ;
                endcase
            end
        end
    end

    // ---------------- checking infrastructure -------------------------------
    int n_chk = 0;
    int n_err = 0;
    logic [67:0] op_q[$];   // {op, dh, dl}
    logic [31:0] mf_q[$];
    logic [15:0] exp_cnt = 16'd0;
    logic [31:0] last_dh = 32'd0, last_dl = 32'd0;
    logic [3:0]  prev_op = 4'd0;
    logic        prev_mfv = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Issued-operation scoreboard: each non-NONE md_op must match the next
    // expected issue and must not last more than one cycle.
    always @(negedge clk) begin
        if (md_op != 4'd0) begin
            logic [67:0] e;
            chk("md_op_one_cycle", {28'd0, prev_op}, 32'd0);
            if (op_q.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL md_op_unexpected: got %0d expected none", md_op);
            end else begin
                e = op_q.pop_front();
                chk("md_op", {28'd0, md_op}, {28'd0, e[67:64]});
                chk("md_dh", md_dh, e[63:32]);
                chk("md_dl", md_dl, e[31:0]);
            end
        end
        prev_op = md_op;
    end

    // MF result scoreboard.
    always @(negedge clk) begin
        if (mf_valid) begin
            chk("mf_valid_pulse", {31'd0, prev_mfv}, 32'd0);
            if (mf_q.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL mf_unexpected: got 0x%08h expected none", mf_data);
            end else begin
                chk("mf_data", mf_data, mf_q.pop_front());
            end
        end
        prev_mfv = mf_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus helpers --------------------------------------
    function automatic bit is_start_cls(input logic [3:0] c);
        return (c >= 4'd1) && (c <= 4'd6);
    endfunction

    // Start op then an MF read right behind it; count the stall cycles.
    task automatic back_to_back(input logic [3:0] scls, input logic [31:0] rs,
                                input logic [31:0] rt, input logic [3:0] rcls,
                                input int exp_stalls, input logic [31:0] exp_mf);
        int stalls = 0;
        @(negedge clk);
        e_valid = 1'b1; e_cls = scls; e_rs = rs; e_rt = rt;
        #1 chk("b2b_start_stall", {31'd0, stall}, 32'd0);
        op_q.push_back({scls, rs, rt}); exp_cnt++;
        @(negedge clk);
        e_cls = rcls;
        for (int i = 0; i < 30; i++) begin
            flush = 1'b0;
            #1;
            if (!stall) break;
            stalls++;
            if (stalls == 3) begin
                flush = 1'b1;
                #1 chk("md_stop_in_wait", {31'd0, md_stop}, 32'd0);
            end
            @(negedge clk);
        end
        chk("b2b_stall_cycles", stalls, exp_stalls);
        mf_q.push_back(exp_mf);
        @(negedge clk);
        e_valid = 1'b0; flush = 1'b0;
        chk("b2b_issue_cnt", {16'd0, issue_cnt}, {16'd0, exp_cnt});
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        logic [3:0]  cls;
        logic [31:0] rs, rt;
        logic [3:0]  exp_op;
        logic        exp_div0;
        logic [31:0] exp_mf;
    } vec_t;

    vec_t tbl[15];

    initial begin
        tbl[0]  = '{4'd1,  32'd3,          32'd5,  4'd1, 1'b0, 32'd0};
        tbl[1]  = '{4'd8,  32'd0,          32'd0,  4'd0, 1'b0, 32'd15};
        tbl[2]  = '{4'd7,  32'd0,          32'd0,  4'd0, 1'b0, 32'd0};
        tbl[3]  = '{4'd2,  32'hFFFF_FFFF,  32'd2,  4'd2, 1'b0, 32'd0};
        tbl[4]  = '{4'd7,  32'd0,          32'd0,  4'd0, 1'b0, 32'd1};
        tbl[5]  = '{4'd4,  32'd7,          32'd0,  4'd4, 1'b1, 32'd0};
        tbl[6]  = '{4'd8,  32'd0,          32'd0,  4'd0, 1'b0, 32'hFFFF_FFFE};
        tbl[7]  = '{4'd3,  32'd100,        32'd7,  4'd3, 1'b0, 32'd0};
        tbl[8]  = '{4'd7,  32'd0,          32'd0,  4'd0, 1'b0, 32'd2};
        tbl[9]  = '{4'd6,  32'h1234_5678,  32'd0,  4'd6, 1'b0, 32'd0};
        tbl[10] = '{4'd8,  32'd0,          32'd0,  4'd0, 1'b0, 32'h1234_5678};
        tbl[11] = '{4'd5,  32'hDEAD_BEEF,  32'd9,  4'd5, 1'b0, 32'd0};
        tbl[12] = '{4'd7,  32'd0,          32'd0,  4'd0, 1'b0, 32'hDEAD_BEEF};
        tbl[13] = '{4'd0,  32'd11,         32'd22, 4'd0, 1'b0, 32'd0};
        tbl[14] = '{4'd12, 32'd33,         32'd44, 4'd0, 1'b0, 32'd0};

        // ---- reset state ----
        repeat (2) @(negedge clk);
        chk("rst_md_op", {28'd0, md_op}, 32'd0);
        chk("rst_md_dh", md_dh, 32'd0);
        chk("rst_md_dl", md_dl, 32'd0);
        chk("rst_mf_valid", {31'd0, mf_valid}, 32'd0);
        chk("rst_mf_data", mf_data, 32'd0);
        chk("rst_div0", {31'd0, div0}, 32'd0);
        chk("rst_issue_cnt", {16'd0, issue_cnt}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // ---- table-driven single instructions from IDLE ----
        for (int k = 0; k < 15; k++) begin
            e_valid = 1'b1; e_cls = tbl[k].cls; e_rs = tbl[k].rs; e_rt = tbl[k].rt;
            #1 chk("vec_stall", {31'd0, stall}, 32'd0);
            if (tbl[k].exp_op != 4'd0) begin
                op_q.push_back({tbl[k].exp_op, tbl[k].rs, tbl[k].rt});
                exp_cnt++;
                last_dh = tbl[k].rs; last_dl = tbl[k].rt;
            end
            if ((tbl[k].cls == 4'd7) || (tbl[k].cls == 4'd8))
                mf_q.push_back(tbl[k].exp_mf);
            @(negedge clk);
            e_valid = 1'b0;
            chk("vec_div0", {31'd0, div0}, {31'd0, tbl[k].exp_div0});
            chk("vec_issue_cnt", {16'd0, issue_cnt}, {16'd0, exp_cnt});
            @(negedge clk);
            chk("vec_div0_clear", {31'd0, div0}, 32'd0);
            repeat (9) @(negedge clk);
            chk("vec_dh_hold", md_dh, last_dh);
            chk("vec_dl_hold", md_dl, last_dl);
            if (is_start_cls(tbl[k].cls))
                chk("vec_busy_done", {31'd0, md_busy}, 32'd0);
        end

        // ---- mult 3*5 then mflo: stalls 7 cycles (ISSUE + WAIT) ----
        back_to_back(4'd1, 32'd3, 32'd5, 4'd8, 7, 32'd15);
        last_dh = 32'd3; last_dl = 32'd5;
        // ---- mthi then mfhi: one stall cycle ----
        back_to_back(4'd5, 32'hCAFE_F00D, 32'd0, 4'd7, 1, 32'hCAFE_F00D);

        // ---- flush during ISSUE cancels the divide ----
        @(negedge clk);
        e_valid = 1'b1; e_cls = 4'd3; e_rs = 32'd9; e_rt = 32'd3;
        #1 chk("fl_accept_stall", {31'd0, stall}, 32'd0);
        op_q.push_back({4'd3, 32'd9, 32'd3});
        @(negedge clk);
        e_valid = 1'b0; flush = 1'b1;
        #1 chk("fl_md_stop", {31'd0, md_stop}, 32'd1);
        chk("fl_cnt_in_issue", {16'd0, issue_cnt}, {16'd0, exp_cnt + 16'd1});
        @(negedge clk);
        flush = 1'b0;
        #1 chk("fl_md_stop_clear", {31'd0, md_stop}, 32'd0);
        chk("fl_cnt_net_zero", {16'd0, issue_cnt}, {16'd0, exp_cnt});
        e_valid = 1'b1; e_cls = 4'd7;
        #1 chk("fl_back_idle", {31'd0, stall}, 32'd0);
        e_valid = 1'b0;
        // flush in IDLE blocks both a start and a read
        @(negedge clk);
        e_valid = 1'b1; e_cls = 4'd5; e_rs = 32'd1; flush = 1'b1;
        @(negedge clk);
        e_cls = 4'd8;
        @(negedge clk);
        e_valid = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("fl_idle_blocked", {16'd0, issue_cnt}, {16'd0, exp_cnt});

        // ---- counter wrap on the 4-bit instance ----
        for (int j = 0; j < 17; j++) begin
            @(negedge clk);
            e_valid = 1'b1; e_cls = 4'd5; e_rs = 32'(j); e_rt = 32'd0;
            op_q.push_back({4'd5, 32'(j), 32'd0});
            exp_cnt++;
            @(negedge clk);
            e_valid = 1'b0;
            chk("cnt_main", {16'd0, issue_cnt}, {16'd0, exp_cnt});
            chk("cnt4_wrap", {28'd0, cnt4}, {28'd0, exp_cnt[3:0]});
        end
        repeat (2) @(negedge clk);

        // ---- asynchronous reset mid-WAIT ----
        e_valid = 1'b1; e_cls = 4'd1; e_rs = 32'd2; e_rt = 32'd2;
        op_q.push_back({4'd1, 32'd2, 32'd2});
        @(negedge clk);
        e_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("ar_md_op", {28'd0, md_op}, 32'd0);
        chk("ar_md_dh", md_dh, 32'd0);
        chk("ar_md_dl", md_dl, 32'd0);
        chk("ar_mf_valid", {31'd0, mf_valid}, 32'd0);
        chk("ar_mf_data", mf_data, 32'd0);
        chk("ar_div0", {31'd0, div0}, 32'd0);
        chk("ar_issue_cnt", {16'd0, issue_cnt}, 32'd0);
        chk("ar_md_stop", {31'd0, md_stop}, 32'd0);
        e_valid = 1'b1; e_cls = 4'd0;
        #1 chk("ar_stall_nonmd", {31'd0, stall}, 32'd0);
        exp_cnt = 16'd0;
        @(negedge clk);
        rst = 1'b1;
        e_cls = 4'd8;
        #1 chk("ar_first_idle", {31'd0, stall}, 32'd0);
        mf_q.push_back(32'd0);
        @(negedge clk);
        e_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("ar_cnt_after", {16'd0, issue_cnt}, 32'd0);

        chk("op_q_drained", op_q.size(), 32'd0);
        chk("mf_q_drained", mf_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/md_issue.md
MD_ISSUE -- requirements
Module: md_issue

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, all state changes on rising edge.
REQ-002 SHALL have ports: rst  input  1  asynchronous active-low reset; rst=0 forces reset state immediately, independent of clk.
REQ-003 SHALL have ports: e_valid  input  1  E-stage instruction valid.
REQ-004 SHALL have ports: e_cls  input  4  E-stage MD class: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 treated as none.
REQ-005 SHALL have ports: e_rs, e_rt  input  32 each  forwarded E-stage operands.
REQ-006 SHALL have ports: flush  input  1  exception/flush of the E-stage instruction.
REQ-007 SHALL have ports: md_busy, md_invalid  input  1 each; md_hi, md_lo  input  32 each  status and results from the multiply/divide unit.
REQ-008 SHALL have ports: md_op  output  4  operation to the multiply/divide unit, shared MD_* encoding; md_dh, md_dl  output  32 each  operands.
REQ-009 SHALL have ports: md_stop  output  1  abort of the current md_op.
REQ-010 SHALL have ports: stall  output  1  freeze F/D/E stages.
REQ-011 SHALL have ports: mf_valid  output  1; mf_data  output  32  MFHI/MFLO result to M stage.
REQ-012 SHALL have ports: div0  output  1  one-cycle pulse: divide by zero issued; issue_cnt  output  16  count of issued MD operations.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-014 "start" class = 1..6; "read" class = 7..8; "md class" = start or read; all qualified by e_valid.
REQ-015 IDLE -> ISSUE on rising edge when start class present, state IDLE, md_busy=0, flush=0; md_op/md_dh/md_dl registered from class/e_rs/e_rt in the same edge.
REQ-016 md_op SHALL be non-NONE during exactly one clock cycle (ISSUE) per issued instruction, and MD_NONE at all other times.
REQ-017 md_dh/md_dl SHALL hold their last issued values outside ISSUE.
REQ-018 ISSUE -> WAIT on the next edge for mult/multu/div/divu; ISSUE -> IDLE for mthi/mtlo.
REQ-019 WAIT -> IDLE on the first rising edge sampling md_busy=0.
REQ-020 stall = md-class instruction in E AND (state != IDLE OR md_busy=1); combinational; stall SHALL be 0 for non-MD instructions in any state.
REQ-021 Issuing instruction SHALL assert stall=0 in its accept cycle, so it leaves E; next MD instruction stalls during ISSUE and WAIT.
REQ-022 Read class accepted when stall=0 and flush=0: mf_data <= md_hi (7) or md_lo (8), mf_valid <= 1 on that edge; mf_valid SHALL be 0 in every other cycle (latency 1, one-cycle pulse).
REQ-023 flush=1 in IDLE SHALL block acceptance of any MD instruction that cycle.
REQ-024 flush=1 during ISSUE SHALL assert md_stop=1 combinationally in that cycle, and the state SHALL return to IDLE; issue_cnt SHALL be decremented back (net zero).
REQ-025 flush in WAIT SHALL have no effect on the in-flight operation; md_stop=0.
REQ-026 div0 pulses one cycle, registered with the accept edge, when class 3/4 accepted with e_rt=0; the operation is still issued.
REQ-027 issue_cnt increments by 1 per accept, 16-bit wrap 0xFFFF -> 0x0000.
REQ-028 md_invalid SHALL be ignored by control (informational only).

Reset
REQ-029 On rst=0: state IDLE, md_op=MD_NONE, md_dh=md_dl=0, mf_valid=0, mf_data=0, div0=0, issue_cnt=0; md_stop=0 and stall=0 unless combinationally driven.
REQ-030 Reset mid-WAIT SHALL return to IDLE without waiting for md_busy; first edge after rst release behaves as IDLE.

Verification
REQ-031 mult rs=3 rt=5 accepted; md_busy high 5 cycles -> md_op=MULT exactly 1 cycle, dh=3 dl=5; following mflo stalls until busy falls, then mf_data=15, mf_valid 1 cycle.
REQ-032 divu rs=7 rt=0 -> div0 pulse 1 cycle, md_op=DIVU issued, issue_cnt +1.
REQ-033 mthi rs=0xDEADBEEF then mfhi next instruction -> ISSUE 1 cycle, mfhi stalls 1 cycle, then mf_data=0xDEADBEEF.
REQ-034 div accepted, flush=1 during ISSUE -> md_stop=1 that cycle, state IDLE next edge, issue_cnt unchanged from pre-issue.
REQ-035 issue_cnt preloaded to 0xFFFF via 65535 mthi issues -> next issue wraps to 0x0000.
REQ-036 rst=0 asserted between edges during WAIT -> all outputs at reset values immediately; stall=0 for non-MD instruction.
